slave_mem_model_stall: RTL and testbench

SLAVE_MEM_MODEL_STALL -- requirements
Module: slave_mem_model_stall

---
 rtl/slave_mem_model_pkg.sv | 15 +
 rtl/slave_mem_model_stall_fifo.sv | 59 +++++
 rtl/slave_mem_model_stall.sv | 118 +++++++++++
 tb/tb_slave_mem_model_stall.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/slave_mem_model_pkg.sv
// Shared constants and types for the stalling slave memory model.
// Holds the LFSR polynomial, default seed, default fill pattern and FSM state type.
package slave_mem_model_pkg;

  // Galois tap mask for x^16+x^14+x^13+x^11+1 (right-shifting form)
  localparam logic [15:0] LfsrPoly           = 16'hB400;
  localparam logic [15:0] LfsrSeedDefault    = 16'hACE1;
  localparam logic [31:0] FillPatternDefault = 32'hDEADBEEF;

  typedef enum logic {
    StInit,
    StRun
  } state_e;

endpackage

// File: rtl/slave_mem_model_stall_fifo.sv
// Response FIFO of 2**W entries, B bits wide; head is shown on rdata_o.
// Storage is cleared on reset so the head output never carries X.
module fifo #(
  parameter int unsigned B = 32,
  parameter int unsigned W = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [B-1:0] wdata_i,
  output logic [B-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned Depth = 2 ** W;

  logic [B-1:0] mem_q [Depth];
  logic [W-1:0] wr_ptr_q, rd_ptr_q;
  logic [W:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  assign full_o  = (cnt_q == (W+1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    do_push = push_i & ~full_o;
    do_pop  = pop_i & ~empty_o;
    cnt_d   = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + (W+1)'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - (W+1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + W'(1);
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/slave_mem_model_stall.sv
// Word-addressed slave memory model with LFSR-driven request/response stalls.
// After reset it fills every word with FILL_PATTERN before accepting requests.
module slave_mem_model_stall
  import slave_mem_model_pkg::*;
#(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MEMSIZE         = 1024,
  parameter int unsigned RESP_DEPTH_LOG2 = 2,
  parameter bit          WR_RESP         = 1'b0,
  parameter bit          STALL_EN        = 1'b1,
  parameter logic [15:0] LFSR_SEED       = LfsrSeedDefault,
  parameter logic [31:0] FILL_PATTERN    = FillPatternDefault
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                slave_req,
  input  logic [31:0]         slave_addr,
  input  logic                slave_cmd,
  input  logic [DATA_W-1:0]   slave_wdata,
  input  logic [DATA_W/8-1:0] slave_be,
  output logic                slave_ack,
  output logic [DATA_W-1:0]   slave_rdata,
  output logic                slave_resp,
  output logic                init_done
);

  localparam int unsigned BeW  = DATA_W / 8;
  localparam int unsigned OffW = $clog2(BeW);
  localparam int unsigned IdxW = $clog2(MEMSIZE);

  logic [DATA_W-1:0] mem_q [MEMSIZE];
  state_e            state_q, state_d;
  logic [IdxW-1:0]   fill_cnt_q, fill_cnt_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [IdxW-1:0]   idx;
  logic [DATA_W-1:0] fill_word;
  logic [DATA_W-1:0] push_data;
  logic              req_rdy, resp_rdy;
  logic              fifo_full, fifo_empty, fifo_push;
  logic              unused_addr;

  // Upper address bits beyond the index simply alias (wrap modulo MEMSIZE)
  assign idx         = slave_addr[OffW +: IdxW];
  assign unused_addr = ^slave_addr;

  always_comb begin
    fill_word = '0;
    for (int i = 0; i < BeW; i++) begin
      fill_word[i*8 +: 8] = FILL_PATTERN[(i % 4)*8 +: 8];
    end
  end

  assign lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrPoly : 16'h0000);
  assign req_rdy  = STALL_EN ? (lfsr_q[1:0] == 2'b00) : 1'b1;
  assign resp_rdy = STALL_EN ? (lfsr_q[3:2] == 2'b00) : 1'b1;

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    unique case (state_q)
      StInit: begin
        fill_cnt_d = fill_cnt_q + IdxW'(1);
        if (fill_cnt_q == IdxW'(MEMSIZE - 1)) begin
          state_d = StRun;
        end
      end
      StRun: ;
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= StInit;
      fill_cnt_q <= '0;
      lfsr_q     <= LFSR_SEED;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      lfsr_q     <= lfsr_d;
    end
  end

  // Full is sampled before any same-cycle pop, so a pop never frees a slot early
  assign slave_ack  = (state_q == StRun) & slave_req & req_rdy & ~fifo_full;
  assign init_done  = (state_q == StRun);
  assign slave_resp = ~fifo_empty & resp_rdy;
  assign fifo_push  = slave_ack & (~slave_cmd | WR_RESP);
  assign push_data  = slave_cmd ? '0 : mem_q[idx];

  // Array contents are not reset; the INIT pass overwrites every word
  always_ff @(posedge clk_i) begin
    if (state_q == StInit) begin
      mem_q[fill_cnt_q] <= fill_word;
    end else if (slave_ack && slave_cmd) begin
      for (int b = 0; b < BeW; b++) begin
        if (slave_be[b]) begin
          mem_q[idx][b*8 +: 8] <= slave_wdata[b*8 +: 8];
        end
      end
    end
  end

  fifo #(
    .B(DATA_W),
    .W(RESP_DEPTH_LOG2)
  ) u_resp_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_i),
    .push_i (fifo_push),
    .pop_i  (slave_resp),
    .wdata_i(push_data),
    .rdata_o(slave_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

endmodule

// File: tb/tb_slave_mem_model_stall.sv
// Randomized bench for slave_mem_model_stall against a transaction-level model.
// The model tracks the memory image, the response queue and the stall LFSR.
module tb_slave_mem_model_stall;

  localparam int unsigned Mem   = 16;
  localparam int unsigned Depth = 4;
  localparam logic [15:0] Seed  = 16'hACE1;
  localparam logic [31:0] Fill  = 32'hDEADBEEF;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        slave_req = 1'b0;
  logic [31:0] slave_addr = '0;
  logic        slave_cmd = 1'b0;
  logic [31:0] slave_wdata = '0;
  logic [3:0]  slave_be = '0;
  logic        slave_ack, slave_resp, init_done;
  logic [31:0] slave_rdata;

  slave_mem_model_stall #(
    .DATA_W(32), .MEMSIZE(Mem), .RESP_DEPTH_LOG2(2), .WR_RESP(1'b1), .STALL_EN(1'b1),
    .LFSR_SEED(Seed), .FILL_PATTERN(Fill)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .slave_req(slave_req), .slave_addr(slave_addr),
    .slave_cmd(slave_cmd), .slave_wdata(slave_wdata), .slave_be(slave_be),
    .slave_ack(slave_ack), .slave_rdata(slave_rdata), .slave_resp(slave_resp),
    .init_done(init_done)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_lfsr = Seed;
  bit          m_run = 1'b0;
  int          m_fill = 0;
  logic [31:0] m_mem [Mem];
  logic [31:0] q[$];
  logic [31:0] dut_log[$];
  logic [31:0] prev_rdata = '0;
  bit          prev_empty = 1'b0;
  bit          last_ack = 1'b0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // One clock: called at a negedge, returns at the next negedge.
  task automatic step(input bit req, input bit cmd, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be);
    bit e_ack, e_resp;
    int idx;
    slave_req = req; slave_cmd = cmd; slave_addr = addr; slave_wdata = wdata; slave_be = be;
    #1;
    e_ack  = m_run && req && (m_lfsr[1:0] == 2'b00) && (q.size() < Depth);
    e_resp = (q.size() > 0) && (m_lfsr[3:2] == 2'b00);
    checks++;
    if (slave_ack !== e_ack) begin
      errors++; $display("FAIL ack: got %b expected %b at %0t", slave_ack, e_ack, $time);
    end
    checks++;
    if (slave_resp !== e_resp) begin
      errors++; $display("FAIL resp: got %b expected %b at %0t", slave_resp, e_resp, $time);
    end
    checks++;
    if (init_done !== m_run) begin
      errors++; $display("FAIL init_done: got %b expected %b at %0t", init_done, m_run, $time);
    end
    if (e_resp) begin
      checks++;
      if (slave_rdata !== q[0]) begin
        errors++; $display("FAIL rdata: got %h expected %h at %0t", slave_rdata, q[0], $time);
      end
    end
    if (q.size() == 0) begin
      checks++;
      if ($isunknown(slave_rdata) || (prev_empty && slave_rdata !== prev_rdata)) begin
        errors++;
        $display("FAIL rdata_idle: got %h expected stable %h at %0t", slave_rdata, prev_rdata,
                 $time);
      end
    end
    if (slave_resp === 1'b1) dut_log.push_back(slave_rdata);
    prev_empty = (q.size() == 0);
    prev_rdata = slave_rdata;
    if (e_resp) void'(q.pop_front());
    if (e_ack) begin
      idx = int'((addr >> 2) % Mem);
      if (cmd) begin
        for (int b = 0; b < 4; b++) if (be[b]) m_mem[idx][b*8 +: 8] = wdata[b*8 +: 8];
        q.push_back(32'h0);
      end else begin
        q.push_back(m_mem[idx]);
      end
    end
    if (!m_run) begin
      m_mem[m_fill] = Fill;
      if (m_fill == Mem - 1) m_run = 1'b1;
      m_fill++;
    end
    m_lfsr   = lfsr_next(m_lfsr);
    last_ack = e_ack;
    @(negedge clk_i);
  endtask

  task automatic issue(input bit cmd, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be);
    int n = 0;
    do begin
      step(1'b1, cmd, addr, wdata, be);
      n++;
    end while (!last_ack && n < 200);
    if (!last_ack) begin
      checks++; errors++;
      $display("FAIL issue_timeout: got no ack expected ack within 200 cycles addr %h", addr);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 200) begin
      step(1'b0, 1'b0, '0, '0, '0);
      n++;
    end
    step(1'b0, 1'b0, '0, '0, '0);
    if (q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d queued expected 0", q.size());
    end
  endtask

  task automatic apply_reset(input int cycles);
    #2;
    rst_i = 1'b0;
    slave_req = 1'($urandom);
    #1;
    checks++;
    if (slave_resp !== 1'b0 || slave_ack !== 1'b0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got resp=%b ack=%b done=%b expected 0 0 0",
               slave_resp, slave_ack, init_done);
    end
    repeat (cycles) @(negedge clk_i);
    m_lfsr = Seed; m_run = 1'b0; m_fill = 0; q.delete(); prev_empty = 1'b0;
    rst_i = 1'b1;
    slave_req = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(3);
    repeat (Mem - 1) step(1'b0, 1'b0, '0, '0, '0);
    checks++;
    if (init_done !== 1'b0) begin
      errors++; $display("FAIL init_early: got %b expected 0", init_done);
    end
    step(1'b0, 1'b0, '0, '0, '0);
    checks++;
    if (init_done !== 1'b1) begin
      errors++; $display("FAIL init_rise: got %b expected 1", init_done);
    end
  endtask

  task automatic test_fill_read();
    dut_log.delete();
    issue(1'b0, 32'h0, '0, '0);
    drain();
    checks++;
    if (dut_log.size() != 1 || dut_log[0] !== Fill) begin
      errors++; $display("FAIL fill_read: got %0d resp first %h expected 1 resp %h",
                         dut_log.size(), (dut_log.size() > 0) ? dut_log[0] : 32'hx, Fill);
    end
  endtask

  task automatic test_byte_enable();
    dut_log.delete();
    issue(1'b1, 32'h8, 32'h11223344, 4'b0011);
    issue(1'b1, 32'hC, 32'h11223344, 4'b0101);
    issue(1'b0, 32'h8, '0, '0);
    issue(1'b0, 32'hC, '0, '0);
    drain();
    checks++;
    if (dut_log.size() != 4 || dut_log[0] !== 32'h0 || dut_log[1] !== 32'h0 ||
        dut_log[2] !== 32'hDEAD3344 || dut_log[3] !== 32'hDE22BE44) begin
      errors++;
      $display("FAIL byte_enable: got %0d resp %p expected {0,0,DEAD3344,DE22BE44}",
               dut_log.size(), dut_log);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d = $urandom;
    dut_log.delete();
    issue(1'b1, 32'h4, d, 4'hF);
    issue(1'b0, 32'h1000_0004, '0, '0);
    issue(1'b0, 32'h4, '0, '0);
    drain();
    checks++;
    if (dut_log.size() != 3 || dut_log[1] !== d || dut_log[2] !== d) begin
      errors++; $display("FAIL wrap: got %p expected {0,%h,%h}", dut_log, d, d);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a = {$urandom_range(0, 255), 2'b00} | ($urandom << 12);
      issue(1'b1, a, $urandom, 4'($urandom));
      issue(1'b0, a, '0, '0);
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom, $urandom, 4'($urandom));
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int n = 0;
    while (q.size() < 3 && n < 300) begin
      step(1'b1, 1'b0, $urandom, '0, '0);
      n++;
    end
    checks++;
    if (q.size() < 3) begin
      errors++; $display("FAIL reset_mid_setup: got %0d queued expected >= 3", q.size());
    end
    apply_reset(2);
    repeat (Mem) step(1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < 100; i++) begin
      step($urandom_range(0, 1) != 0, 1'($urandom), $urandom, $urandom, 4'($urandom));
    end
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk_i);
    test_reset();
    test_fill_read();
    test_byte_enable();
    test_wrap();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
